// File: rtl/text_terminal.sv
// Character-stream terminal engine: interprets a byte stream, owns the text VRAM
// and scrolls by advancing top_row instead of moving memory.
module text_terminal #(
   parameter int unsigned COLS  = 100,
   parameter int unsigned ROWS  = 30,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic       clk,
   input  logic       reset_low,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic       vram_valid,
   input  logic [4:0] vram_row,
   input  logic [6:0] vram_col,
   output logic [7:0] vram_byte,
   output logic [4:0] top_row,
   output logic [4:0] cursor_row,
   output logic [6:0] cursor_col
);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR_ROW,
      CLEAR_SCREEN
   } state_t;

   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);

   state_t      r_state;
   logic        r_in_ready;
   logic [4:0]  r_top_row;
   logic [4:0]  r_cur_row;
   logic [6:0]  r_cur_col;
   logic [4:0]  r_clr_row;
   logic [6:0]  r_clr_col;
   logic [7:0]  r_vram_byte;
   logic [7:0]  r_mem [0:ROWS*128-1];

   logic        w_accept;
   logic        w_printable;
   logic        w_newline;
   logic        w_last_row;
   logic [4:0]  w_diff;
   logic [4:0]  w_logical;
   logic        w_we;
   logic [11:0] w_waddr;
   logic [7:0]  w_wdata;

   function automatic logic [4:0] inc_row(input logic [4:0] r);
      return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
   endfunction

   assign w_accept    = in_valid && r_in_ready && (r_state == IDLE);
   assign w_printable = (in_byte >= 8'h20) && (in_byte != 8'h7F);
   assign w_newline   = w_accept &&
                        ((in_byte == 8'h0A) || (w_printable && (r_cur_col == LAST_COL)));

   // Logical row is the cursor distance below top_row, modulo ROWS (not 32).
   assign w_diff     = r_cur_row - r_top_row;
   assign w_logical  = (r_cur_row < r_top_row) ? w_diff + 5'(ROWS) : w_diff;
   assign w_last_row = (w_logical == LAST_ROW);

   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = BLANK;
      case (r_state)
         CLEAR_SCREEN: begin
            w_we    = 1'b1;
            w_waddr = {r_clr_row, r_clr_col};
         end
         CLEAR_ROW: begin
            w_we    = 1'b1;
            w_waddr = {r_cur_row, r_clr_col};
         end
         default: begin
            if (w_accept && w_printable) begin
               w_we    = 1'b1;
               w_waddr = {r_cur_row, r_cur_col};
               w_wdata = in_byte;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         r_vram_byte <= '0;
      end else if (vram_valid) begin
         r_vram_byte <= r_mem[{vram_row, vram_col}];
      end
   end

   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         r_state    <= CLEAR_SCREEN;
         r_in_ready <= 1'b0;
         r_top_row  <= '0;
         r_cur_row  <= '0;
         r_cur_col  <= '0;
         r_clr_row  <= '0;
         r_clr_col  <= '0;
      end else begin
         case (r_state)
            CLEAR_SCREEN: begin
               if (r_clr_col == LAST_COL) begin
                  r_clr_col <= '0;
                  if (r_clr_row == LAST_ROW) begin
                     r_clr_row  <= '0;
                     r_state    <= IDLE;
                     r_in_ready <= 1'b1;
                     r_top_row  <= '0;
                     r_cur_row  <= '0;
                     r_cur_col  <= '0;
                  end else begin
                     r_clr_row <= r_clr_row + 5'd1;
                  end
               end else begin
                  r_clr_col <= r_clr_col + 7'd1;
               end
            end

            CLEAR_ROW: begin
               if (r_clr_col == LAST_COL) begin
                  r_clr_col  <= '0;
                  r_state    <= IDLE;
                  r_in_ready <= 1'b1;
               end else begin
                  r_clr_col <= r_clr_col + 7'd1;
               end
            end

            default: begin
               if (w_accept) begin
                  if (w_printable) begin
                     r_cur_col <= (r_cur_col == LAST_COL) ? 7'd0 : r_cur_col + 7'd1;
                  end else begin
                     case (in_byte)
                        8'h0D: r_cur_col <= '0;
                        8'h08: if (r_cur_col != 7'd0) r_cur_col <= r_cur_col - 7'd1;
                        8'h0C: begin
                           r_state    <= CLEAR_SCREEN;
                           r_in_ready <= 1'b0;
                           r_clr_row  <= '0;
                           r_clr_col  <= '0;
                        end
                        default: ;
                     endcase
                  end
               end
               // Newline from LF or from wrapping past the last column.
               if (w_newline) begin
                  r_cur_row <= inc_row(r_cur_row);
                  if (w_last_row) begin
                     r_top_row  <= inc_row(r_top_row);
                     r_state    <= CLEAR_ROW;
                     r_in_ready <= 1'b0;
                     r_clr_col  <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign vram_byte  = r_vram_byte;
   assign top_row    = r_top_row;
   assign cursor_row = r_cur_row;
   assign cursor_col = r_cur_col;

endmodule

// File: doc/text_terminal.md
Name: text_terminal

Overview:
Character-stream terminal engine that owns the 100x30 text VRAM feeding the HDMI text pipeline. It accepts a byte stream via a valid/ready handshake and interprets control codes. It maintains a cursor and writes glyph codes into VRAM. Scrolling is done by advancing top_row and clearing the newly exposed row, never by copying memory. Its read port serves the display's per-character fetch with one-cycle registered latency.

Parameters:
COLS, 100, characters per row (col address 7 bits)
ROWS, 30, rows in buffer (row address 5 bits)
BLANK, 8'h20, byte written by clear operations

Ports:
clk  input  1  pixel-domain clock
reset_low  input  1  asynchronous active-low reset
in_valid  input  1  in_byte offered
in_ready  output  1  byte accepted when in_valid & in_ready
in_byte  input  8  character/control code
vram_valid  input  1  display read enable
vram_row  input  5  display read physical row, 0..ROWS-1
vram_col  input  7  display read column, 0..COLS-1
vram_byte  output  8  read data, registered
top_row  output  5  physical row shown at top of screen
cursor_row  output  5  cursor physical row
cursor_col  output  7  cursor column

Behaviour:
- Memory: ROWS x 128 x 8 simple dual-port RAM, address {row,col}. Only columns 0..COLS-1 are written. No reset on contents.
- Read port: vram_byte <= mem[{vram_row,vram_col}] on the clk edge where vram_valid=1. Data is valid the following cycle. vram_byte holds when vram_valid=0. A same-cycle read and write to one address returns the old data.
- Reset (async assert, sync release): top_row=0, cursor 0/0, vram_byte=0, in_ready=0. FSM enters CLEAR_SCREEN.
- FSM states: IDLE, CLEAR_ROW, CLEAR_SCREEN.
- IDLE: in_ready=1. At most one byte is consumed per cycle and processed that cycle:
  - 0x0D CR: cursor_col=0.
  - 0x0A LF: newline. cursor_col is unchanged.
  - 0x08 BS: cursor_col-1 if >0, else no change. No erase.
  - 0x0C FF: enter CLEAR_SCREEN.
  - 0x20-0x7E and 0x80-0xFF: write to mem[cursor]. If cursor_col<COLS-1, cursor_col+1. Otherwise cursor_col=0 and a newline is performed in the same cycle.
  - All other codes are consumed and ignored.
- Newline: logical = (cursor_row - top_row) mod ROWS.
  - If logical<ROWS-1: cursor_row=(cursor_row+1) mod ROWS.
  - Otherwise (scroll): cursor_row and top_row both advance mod ROWS, and the FSM enters CLEAR_ROW on the new cursor_row.
- CLEAR_ROW: in_ready=0. Writes BLANK to cols 0..COLS-1 of cursor_row, one per cycle (COLS cycles), then returns to IDLE. top_row has already updated, so the display may briefly show stale content in that row (accepted).
- CLEAR_SCREEN: in_ready=0. Writes BLANK to every row/col, row-major from physical 0,0 (ROWS*COLS cycles). Then top_row=0, cursor 0/0, FSM returns to IDLE.
- Wrap: row arithmetic wraps ROWS-1 to 0, never to 31. Col counter never exceeds COLS-1.
- Reset mid-clear aborts immediately. The clear restarts from 0,0 after release.
- cursor/top_row outputs are registered and update the cycle after the accepting edge.

Test Plan:
- Reset, then wait: in_ready=0 for exactly 3000 cycles, then 1. Reading any {r<30,c<100} returns 0x20 one cycle after vram_valid.
- Send "AB" at 0/0: mem[0][0]=0x41, mem[0][1]=0x42, cursor_col=2. Then BS, CR gives cursor_col=1 then 0; mem unchanged.
- Send 100 x 'X' from col 0 row 0: row 0 is all 0x58, cursor 1/0, top_row=0, no stall.
- Cursor at logical row 29 with top_row=0; send LF: top_row=1, cursor_row=0, in_ready=0 for exactly 100 cycles, physical row 0 cleared to 0x20. Repeat 30 LFs: top_row wraps 29 to 0.
- Send FF after arbitrary text: 3000-cycle stall, then all cells 0x20, top_row=0, cursor 0/0. Assert reset_low at cycle 1500 of the clear: outputs reset immediately and the clear restarts.
- Concurrent display read of an address written the same cycle: vram_byte returns the pre-write value, and the next read returns the new value.
